// File: rtl/pe_pkg.sv
// pe_pkg: shared helpers and default geometry for the pipelined priority encoder.
package pe_pkg;

  // Ceiling log2; returns 0 for v <= 1
  function automatic int pe_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Default geometry (32-bit vector, 8-bit groups)
  localparam int PE_WIDTH = 32;
  localparam int PE_GROUP = 8;
  localparam int NGRP     = PE_WIDTH / PE_GROUP;
  localparam int IW       = pe_clog2(PE_WIDTH);
  localparam int GW       = pe_clog2(PE_GROUP);
  localparam int SW       = pe_clog2(NGRP);

endpackage

// File: rtl/pe_if.sv
// pe_if: request/result handshake bundle for pe_pipe.
// With PE_ONEHOT_EN defined the bundle also carries out_onehot.
interface pe_if import pe_pkg::*; #(
  parameter int WIDTH = PE_WIDTH
) ();
  localparam int LIW = pe_clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [LIW-1:0]   out_idx;
  logic             out_hit;
`ifdef PE_ONEHOT_EN
  logic [WIDTH-1:0] out_onehot;
`endif

`ifdef PE_ONEHOT_EN
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_idx, out_hit, out_onehot);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_idx, out_hit, out_onehot);
`else
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_idx, out_hit);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_idx, out_hit);
`endif

endinterface

// File: rtl/pe_grp_enc.sv
// pe_grp_enc: combinational GROUP-bit priority encoder.
// Used per group in stage 1 and as the group selector in stage 2.
module pe_grp_enc import pe_pkg::*; #(
  parameter int GROUP     = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDXW     = pe_clog2(GROUP)
) (
  input  logic [GROUP-1:0] i_vec,
  output logic [IDXW-1:0]  o_idx,
  output logic             o_any
);

  assign o_any = |i_vec;

  // Scan so the winning bit is the last one written; empty vector gives 0
  always_comb begin
    o_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < GROUP; i++)
        if (i_vec[i]) o_idx = IDXW'(i);
    end else begin
      for (int i = GROUP - 1; i >= 0; i--)
        if (i_vec[i]) o_idx = IDXW'(i);
    end
  end

endmodule

// File: rtl/pe_pipe.sv
// pe_pipe: three-stage pipelined priority encoder with valid/ready flow.
//   stage 1: per-group encoders, stage 2: group select, stage 3: index assembly.
// Optional: define PE_ONEHOT_EN to add a registered one-hot copy of the result.
module pe_pipe import pe_pkg::*; #(
  parameter int WIDTH     = PE_WIDTH,
  parameter int GROUP     = PE_GROUP,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic clk,
  input  logic rst,   // asynchronous, active low
  pe_if.slave  bus
);

  localparam int P_NGRP = WIDTH / GROUP;
  localparam int P_IW   = pe_clog2(WIDTH);
  localparam int P_GW   = pe_clog2(GROUP);
  localparam int P_SW   = pe_clog2(P_NGRP);

  // Stage valids live in one shift register indexed by stage number
  logic [3:1] r_vld_pipe;
  logic [3:1] w_adv;

  // Stage 1 registers
  logic [P_NGRP-1:0][P_GW-1:0] r_lev1;
  logic [P_NGRP-1:0]           r_any1;
  // Stage 2 registers
  logic [P_NGRP-1:0][P_GW-1:0] r_lev2;
  logic [P_SW-1:0]             r_sel2;
  logic                        r_hit2;
  // Stage 3 registers
  logic [P_IW-1:0]             r_idx3;
  logic                        r_hit3;

  logic [P_NGRP-1:0][P_GW-1:0] w_lev0;
  logic [P_NGRP-1:0]           w_any0;
  logic [P_SW-1:0]             w_sel;
  logic                        w_hit;
  logic [P_IW-1:0]             w_idx3;

  // A stage may advance when it is empty or its successor is advancing
  assign w_adv[3]     = !r_vld_pipe[3] || bus.out_ready;
  assign w_adv[2]     = !r_vld_pipe[2] || w_adv[3];
  assign w_adv[1]     = !r_vld_pipe[1] || w_adv[2];
  assign bus.in_ready = w_adv[1];

  // Stage 1 encoders, one per group
  for (genvar g = 0; g < P_NGRP; g++) begin : g_grp
    pe_grp_enc #(.GROUP(GROUP), .MSB_FIRST(MSB_FIRST)) u_enc (
      .i_vec (bus.in_data[g*GROUP +: GROUP]),
      .o_idx (w_lev0[g]),
      .o_any (w_any0[g])
    );
  end

  // Stage 2 selector: same encoder, one bit per group
  pe_grp_enc #(.GROUP(P_NGRP), .MSB_FIRST(MSB_FIRST)) u_sel (
    .i_vec (r_any1),
    .o_idx (w_sel),
    .o_any (w_hit)
  );

  // Stage 3 index: winning group on top, its in-group index below
  assign w_idx3 = {r_sel2, r_lev2[r_sel2]};

  // Valid shift register; a bubble enters when the upstream stage is empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_pipe <= '0;
    end else begin
      if (w_adv[1]) r_vld_pipe[1] <= bus.in_valid;
      if (w_adv[2]) r_vld_pipe[2] <= r_vld_pipe[1];
      if (w_adv[3]) r_vld_pipe[3] <= r_vld_pipe[2];
    end
  end

  // Stage 1 data: loads only on a real transfer so stalled data holds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lev1 <= '0;
      r_any1 <= '0;
    end else if (w_adv[1] && bus.in_valid) begin
      r_lev1 <= w_lev0;
      r_any1 <= w_any0;
    end
  end

  // Stage 2 data: group select plus carried in-group indices
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lev2 <= '0;
      r_sel2 <= '0;
      r_hit2 <= 1'b0;
    end else if (w_adv[2] && r_vld_pipe[1]) begin
      r_lev2 <= r_lev1;
      r_sel2 <= w_sel;
      r_hit2 <= w_hit;
    end
  end

  // Stage 3 data: assembled index and hit flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx3 <= '0;
      r_hit3 <= 1'b0;
    end else if (w_adv[3] && r_vld_pipe[2]) begin
      r_idx3 <= w_idx3;
      r_hit3 <= r_hit2;
    end
  end

`ifdef PE_ONEHOT_EN
  logic [WIDTH-1:0] r_onehot3;
  logic [WIDTH-1:0] w_onehot;

  assign w_onehot = r_hit2 ? (WIDTH'(1) << w_idx3) : '0;

  // One-hot copy of the result, loaded alongside stage 3
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            r_onehot3 <= '0;
    else if (w_adv[3] && r_vld_pipe[2])  r_onehot3 <= w_onehot;
  end

  assign bus.out_onehot = r_onehot3;
`endif

  assign bus.out_valid = r_vld_pipe[3];
  assign bus.out_idx   = r_idx3;
  assign bus.out_hit   = r_hit3;

endmodule

// File: tb/tb_pe_pipe.sv
// tb_pe_pipe: scoreboard bench for pe_pipe; runs an LSB-first and an
// MSB-first instance side by side on the same stimulus.
module tb_pe_pipe;
  import pe_pkg::*;

  typedef struct {
    logic [4:0]  idx;
    logic        hit;
    logic [31:0] oh;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  exp_t q0[$];
  exp_t q1[$];
  logic s_ovld;
  logic s_irdy;
  logic [4:0] s_idx0;

  pe_if #(.WIDTH(32)) b0 ();
  pe_if #(.WIDTH(32)) b1 ();

  pe_pipe #(.WIDTH(32), .GROUP(8), .MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  pe_pipe #(.WIDTH(32), .GROUP(8), .MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain bit scan over the whole vector
  function automatic exp_t model(input logic [31:0] d, input bit msb);
    exp_t e;
    bit   found;
    found = 1'b0;
    e.idx = '0;
    e.hit = |d;
    e.oh  = '0;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) begin
        if (msb || !found) e.idx = 5'(i);
        found = 1'b1;
      end
    end
    if (e.hit) e.oh = 32'd1 << e.idx;
    return e;
  endfunction

  // One clock of stimulus; called at a falling edge, samples 1ns later,
  // pushes accepted vectors and checks the head of each scoreboard.
  task automatic cyc(input logic v, input logic [31:0] d, input logic ordy, output logic acc);
    exp_t e;
    b0.in_valid = v; b0.in_data = d; b0.out_ready = ordy;
    b1.in_valid = v; b1.in_data = d; b1.out_ready = ordy;
    #1;
    s_ovld = b0.out_valid;
    s_irdy = b0.in_ready;
    s_idx0 = b0.out_idx;
    acc    = v && b0.in_ready;
    if (v && b0.in_ready) q0.push_back(model(d, 1'b0));
    if (v && b1.in_ready) q1.push_back(model(d, 1'b1));
    if (b0.out_valid) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_bad++;
        $display("FAIL lsb_spurious: out_valid=1 idx=%0d, expected no result", b0.out_idx);
      end else begin
        e = q0[0];
        if (b0.out_idx !== e.idx || b0.out_hit !== e.hit) begin
          n_bad++;
          $display("FAIL lsb_result: idx=%0d hit=%0b, expected idx=%0d hit=%0b",
                   b0.out_idx, b0.out_hit, e.idx, e.hit);
        end
`ifdef PE_ONEHOT_EN
        n_cmp++;
        if (b0.out_onehot !== e.oh) begin
          n_bad++;
          $display("FAIL lsb_onehot: got %h, expected %h", b0.out_onehot, e.oh);
        end
`endif
        if (ordy) void'(q0.pop_front());
      end
    end
    if (b1.out_valid) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL msb_spurious: out_valid=1 idx=%0d, expected no result", b1.out_idx);
      end else begin
        e = q1[0];
        if (b1.out_idx !== e.idx || b1.out_hit !== e.hit) begin
          n_bad++;
          $display("FAIL msb_result: idx=%0d hit=%0b, expected idx=%0d hit=%0b",
                   b1.out_idx, b1.out_hit, e.idx, e.hit);
        end
`ifdef PE_ONEHOT_EN
        n_cmp++;
        if (b1.out_onehot !== e.oh) begin
          n_bad++;
          $display("FAIL msb_onehot: got %h, expected %h", b1.out_onehot, e.oh);
        end
`endif
        if (ordy) void'(q1.pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    logic acc;
    for (int i = 0; i < 40 && (q0.size() != 0 || q1.size() != 0); i++)
      cyc(1'b0, 32'h0, 1'b1, acc);
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d/%0d results missing, expected 0", name, q0.size(), q1.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    b0.in_valid = 1'b0; b0.in_data = '0; b0.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (b0.out_valid !== 1'b0 || b0.out_idx !== 5'd0 || b0.out_hit !== 1'b0 ||
        b0.in_ready !== 1'b1 || b1.out_valid !== 1'b0 || b1.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state: vld=%b idx=%0d hit=%b rdy=%b vld1=%b rdy1=%b, expected 0 0 0 1 0 1",
               b0.out_valid, b0.out_idx, b0.out_hit, b0.in_ready, b1.out_valid, b1.in_ready);
    end
`ifdef PE_ONEHOT_EN
    n_cmp++;
    if (b0.out_onehot !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_onehot: got %h, expected 0", b0.out_onehot);
    end
`endif
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    logic acc;
    cyc(1'b1, 32'h0000_0100, 1'b1, acc);
    n_cmp++;
    if (acc !== 1'b1) begin
      n_bad++;
      $display("FAIL lat_accept: accepted=%b, expected 1", acc);
    end
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, 32'h0, 1'b1, acc);
      n_cmp++;
      if (s_ovld !== (k == 3)) begin
        n_bad++;
        $display("FAIL lat_cycle%0d: out_valid=%b, expected %b", k, s_ovld, (k == 3));
      end
    end
    n_cmp++;
    if (s_idx0 !== 5'd8) begin
      n_bad++;
      $display("FAIL lat_idx: got %0d, expected 8", s_idx0);
    end
    drain("lat");
  endtask

  task automatic test_patterns();
    logic [31:0] pat [8];
    logic acc;
    pat = '{32'h8000_0001, 32'h00F0_0000, 32'h0, 32'h0001_0400,
            32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_0080, 32'h0100_0000};
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, pat[i], 1'b1, acc);
      n_cmp++;
      if (acc !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_accept%0d: accepted=%b, expected 1", i, acc);
      end
    end
    drain("pat");
  endtask

  task automatic test_backpressure();
    logic [31:0] d [5];
    logic acc;
    int   i, t;
    d = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h10};
    i = 0;
    t = 0;
    while (i < 5 && t < 40) begin
      cyc(1'b1, d[i], (t >= 4), acc);
      if (t == 3) begin
        n_cmp++;
        if (s_irdy !== 1'b0) begin
          n_bad++;
          $display("FAIL bp_full_ready: in_ready=%b, expected 0", s_irdy);
        end
      end
      if (acc) i++;
      t++;
    end
    n_cmp++;
    if (i != 5) begin
      n_bad++;
      $display("FAIL bp_accepted: %0d vectors, expected 5", i);
    end
    drain("bp");
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic acc, v;
    int   sent, t;
    sent = 0;
    t    = 0;
    v    = 1'b0;
    d    = '0;
    while (sent < 40 && t < 600) begin
      if (!v) begin
        v = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0:       d = 32'h0;
          1:       d = 32'h1 << $urandom_range(0, 31);
          2:       d = $urandom & $urandom & $urandom;
          default: d = $urandom;
        endcase
      end
      cyc(v, d, ($urandom_range(0, 2) != 0), acc);
      if (acc) begin
        sent++;
        v = 1'b0;
      end
      t++;
    end
    n_cmp++;
    if (sent != 40) begin
      n_bad++;
      $display("FAIL rnd_accepted: %0d vectors, expected 40", sent);
    end
    drain("rnd");
  endtask

  task automatic test_reset_mid();
    logic acc;
    cyc(1'b1, 32'h0000_1000, 1'b0, acc);
    cyc(1'b1, 32'h0000_2000, 1'b0, acc);
    cyc(1'b1, 32'h0000_4000, 1'b0, acc);
    b0.in_valid = 1'b0; b1.in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (b0.out_valid !== 1'b0 || b1.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid: vld=%b vld1=%b rdy=%b, expected 0 0 1",
               b0.out_valid, b1.out_valid, b0.in_ready);
    end
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cyc(1'b1, 32'h0000_0040, 1'b1, acc);
    for (int k = 0; k < 2; k++) cyc(1'b0, 32'h0, 1'b1, acc);
    n_cmp++;
    if (s_ovld !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_stale: out_valid=%b before first new result, expected 0", s_ovld);
    end
    cyc(1'b0, 32'h0, 1'b1, acc);
    n_cmp++;
    if (s_ovld !== 1'b1 || s_idx0 !== 5'd6) begin
      n_bad++;
      $display("FAIL rst_first: vld=%b idx=%0d, expected 1 6", s_ovld, s_idx0);
    end
    drain("rst");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_latency();
    test_patterns();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule
